// File: rtl/pmm_feeder.sv
// Host-side feeder for one PMM port: buffers bus writes in a FIFO and presents them over the DATA_VALID/READY_STATUS handshake.
// Optional watchdog is built when PMM_FEEDER_TIMEOUT_EN is defined.
module pmm_feeder #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [63:0]              wr_data,
  input  logic [15:0]              wr_ctrl,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [63:0]              INP_DATA,
  output logic [15:0]              INP_CONTROL,
  output logic                     DATA_VALID,
  input  logic                     READY_STATUS,
  input  logic                     ACCEPTED_STATUS,
  output logic                     result_valid,
  output logic                     result_match,
  input  logic                     result_clear,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t        state, state_next;
  logic [79:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          drain_armed;
  logic          push, pop, load, load_next, flush, capture, wd_rst, wd_hit;
  logic          transfer, stalled, dv_next;
  logic [79:0]   next_word;

  assign fifo_count = count;
  assign fifo_full  = (count == CW'(DEPTH));
  assign busy       = (state != IDLE) || (count != '0);
  assign transfer   = DATA_VALID && READY_STATUS;
  assign stalled    = result_valid && !result_clear;
  assign push       = wr_en && !fifo_full && !flush;

  // The entry behind the head; when it does not exist yet, a same-cycle write is forwarded.
  assign next_word = (count > CW'(1)) ? mem[rd_ptr + AW'(1)] : {wr_ctrl, wr_data};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    load_next  = 1'b0;
    dv_next    = DATA_VALID;
    flush      = 1'b0;
    capture    = 1'b0;
    wd_rst     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load       = 1'b1;
          dv_next    = 1'b1;
          wd_rst     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (transfer) begin
          pop    = 1'b1;
          wd_rst = 1'b1;
          if (INP_CONTROL[15]) begin
            dv_next    = 1'b0;
            state_next = DRAIN;
          end else if ((count > CW'(1)) || (wr_en && !fifo_full)) begin
            load      = 1'b1;
            load_next = 1'b1;
          end else begin
            dv_next    = 1'b0;
            state_next = IDLE;
          end
        end else if (wd_hit) begin
          flush      = 1'b1;
          dv_next    = 1'b0;
          state_next = IDLE;
        end
      end
      DRAIN: begin
        // A pending unread result blocks the capture until software clears it.
        if (drain_armed && READY_STATUS && !stalled) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (!stalled && wd_hit) begin
          flush      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_ctrl, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      INP_DATA     <= '0;
      INP_CONTROL  <= '0;
      DATA_VALID   <= 1'b0;
      result_valid <= 1'b0;
      result_match <= 1'b0;
      drain_armed  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (result_clear)  overflow <= 1'b0;
      if (load) begin
        if (load_next) {INP_CONTROL, INP_DATA} <= next_word;
        else           {INP_CONTROL, INP_DATA} <= mem[rd_ptr];
      end
      DATA_VALID <= dv_next;
      if (capture) begin
        result_match <= ACCEPTED_STATUS;
        result_valid <= 1'b1;
      end else if (result_clear) begin
        result_valid <= 1'b0;
      end
      // Holds off the capture for the first cycle spent in DRAIN.
      drain_armed <= (state == DRAIN);
    end
  end

`ifdef PMM_FEEDER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd;
  logic            counting;
  logic            timeout_q;

  assign counting    = (state == SEND) || ((state == DRAIN) && !stalled);
  assign wd_hit      = (wd == WD_W'(TIMEOUT - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd        <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (wd_rst)        wd <= '0;
      else if (counting) wd <= wd + WD_W'(1);
      if (flush)             timeout_q <= 1'b1;
      else if (result_clear) timeout_q <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_wd_rst;
  assign unused_wd_rst = wd_rst;
  assign wd_hit        = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pmm_feeder.sv
// Self-checking bench for pmm_feeder: a vector table, directed corner-case sequences,
// then randomized traffic against a queue-based reference model.
module tb_pmm_feeder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [63:0]   wr_data;
  logic [15:0]   wr_ctrl;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [63:0]   INP_DATA;
  logic [15:0]   INP_CONTROL;
  logic          DATA_VALID;
  logic          READY_STATUS;
  logic          ACCEPTED_STATUS;
  logic          result_valid;
  logic          result_match;
  logic          result_clear;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [79:0] model_q[$];

  typedef struct {
    logic          wr;
    logic [63:0]   data;
    logic [15:0]   ctrl;
    logic          rdy;
    logic          acc;
    logic          clr;
    logic          exp_dv;
    logic [63:0]   exp_data;
    logic [15:0]   exp_ctrl;
    logic [CW-1:0] exp_count;
    logic          exp_rv;
    logic          exp_rm;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[9];

  pmm_feeder #(.DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ctrl(wr_ctrl),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow),
    .INP_DATA(INP_DATA), .INP_CONTROL(INP_CONTROL), .DATA_VALID(DATA_VALID),
    .READY_STATUS(READY_STATUS), .ACCEPTED_STATUS(ACCEPTED_STATUS),
    .result_valid(result_valid), .result_match(result_match), .result_clear(result_clear),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic w, input logic [63:0] d, input logic [15:0] c,
                               input logic rdy, input logic acc, input logic clr);
    wr_en = w; wr_data = d; wr_ctrl = c;
    READY_STATUS = rdy; ACCEPTED_STATUS = acc; result_clear = clr;
    step();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_full"},     64'(fifo_full),    64'd0);
    checkOutput({tag, "_count"},    64'(fifo_count),   64'd0);
    checkOutput({tag, "_overflow"}, 64'(overflow),     64'd0);
    checkOutput({tag, "_data"},     INP_DATA,          64'd0);
    checkOutput({tag, "_ctrl"},     64'(INP_CONTROL),  64'd0);
    checkOutput({tag, "_dv"},       64'(DATA_VALID),   64'd0);
    checkOutput({tag, "_rv"},       64'(result_valid), 64'd0);
    checkOutput({tag, "_rm"},       64'(result_match), 64'd0);
    checkOutput({tag, "_busy"},     64'(busy),         64'd0);
    checkOutput({tag, "_tmo"},      64'(timeout_err),  64'd0);
  endtask

  // Drains the FIFO with READY held high and compares the transferred words with exp_q.
  task automatic drainCheck(input string tag);
    got_q.delete();
    wr_en = 1'b0; READY_STATUS = 1'b1; result_clear = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (DATA_VALID) got_q.push_back(INP_DATA);
      step();
    end
    checkOutput({tag, "_xfer_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) checkOutput($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    end
    checkOutput({tag, "_count_end"}, 64'(fifo_count), 64'd0);
  endtask

  localparam logic [63:0] D0 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] D1 = 64'h2222_0000_0000_0002;
  localparam logic [63:0] D2 = 64'h3333_0000_0000_0003;
  localparam logic [63:0] BAD = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin
    logic        found;
    logic        w, rdy, acc, clr;
    logic [63:0] d;
    logic [15:0] c;
    logic [79:0] head;
    int          pre;

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_ctrl = '0;
    READY_STATUS = 1'b0; ACCEPTED_STATUS = 1'b0; result_clear = 1'b0;
    step(); step();
    checkResetValues("reset");
    rst = 1'b0;

    // Three-word job with READY and ACCEPTED high: back-to-back words, result two edges after LAST.
    vecs[0] = '{1'b1, D0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'h0000, CW'(1), 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, D1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b1, D0,    16'h0001, CW'(2), 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, D2, 16'h8003, 1'b1, 1'b1, 1'b0, 1'b1, D1,    16'h0002, CW'(2), 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 64'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b1, D2,    16'h8003, CW'(1), 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 64'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, D2,    16'h8003, CW'(0), 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 64'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, D2,    16'h8003, CW'(0), 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 64'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, D2,    16'h8003, CW'(0), 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 64'h0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, D2,    16'h8003, CW'(0), 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 64'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, D2,    16'h8003, CW'(0), 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].ctrl, vecs[i].rdy, vecs[i].acc, vecs[i].clr);
      checkOutput($sformatf("vec%0d_dv", i),    64'(DATA_VALID),   64'(vecs[i].exp_dv));
      checkOutput($sformatf("vec%0d_data", i),  INP_DATA,          vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_ctrl", i),  64'(INP_CONTROL),  64'(vecs[i].exp_ctrl));
      checkOutput($sformatf("vec%0d_count", i), 64'(fifo_count),   64'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_rv", i),    64'(result_valid), 64'(vecs[i].exp_rv));
      checkOutput($sformatf("vec%0d_rm", i),    64'(result_match), 64'(vecs[i].exp_rm));
      checkOutput($sformatf("vec%0d_busy", i),  64'(busy),         64'(vecs[i].exp_busy));
    end

    // Backpressure: one queued word held stable while READY is low, then exactly one transfer.
    applyStimulus(1'b1, 64'hAAAA_5555_0000_0010, 16'h0010, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("bp_hold%0d_data", i), INP_DATA, 64'hAAAA_5555_0000_0010);
      checkOutput($sformatf("bp_hold%0d_ctrl", i), 64'(INP_CONTROL), 64'h0010);
      checkOutput($sformatf("bp_hold%0d_dv", i), 64'(DATA_VALID), 64'd1);
      checkOutput($sformatf("bp_hold%0d_count", i), 64'(fifo_count), 64'd1);
    end
    applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_after_dv", 64'(DATA_VALID), 64'd0);
    checkOutput("bp_after_count", 64'(fifo_count), 64'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("bp_idle%0d_dv", i), 64'(DATA_VALID), 64'd0);
    end

    // Fill to DEPTH with READY low, attempt one more write, then drain in order across the wrap.
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = {32'hF111_0000, 32'(i)};
      exp_q.push_back(d);
      applyStimulus(1'b1, d, 16'(i), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("fill_full", 64'(fifo_full), 64'd1);
    checkOutput("fill_overflow_pre", 64'(overflow), 64'd0);
    applyStimulus(1'b1, BAD, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_full_after9", 64'(fifo_full), 64'd1);
    checkOutput("fill_count_after9", 64'(fifo_count), 64'(DEPTH));
    checkOutput("fill_overflow", 64'(overflow), 64'd1);
    drainCheck("fill_drain");
    applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("overflow_cleared", 64'(overflow), 64'd0);

    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = {32'hF222_0000, 32'(i)};
      exp_q.push_back(d);
      applyStimulus(1'b1, d, 16'(i + 16), 1'b0, 1'b0, 1'b0);
    end
    drainCheck("wrap_drain");

    // Second job ends while the first result is unread: it waits until result_clear.
    applyStimulus(1'b1, 64'h0000_0000_0000_0A01, 16'h8000, 1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (result_valid) begin found = 1'b1; break; end
      applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    end
    checkOutput("job1_result_seen", 64'(found), 64'd1);
    checkOutput("job1_rm", 64'(result_match), 64'd1);
    applyStimulus(1'b1, 64'h0000_0000_0000_0A02, 16'h8000, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("job2_stall_rv", 64'(result_valid), 64'd1);
    checkOutput("job2_stall_rm", 64'(result_match), 64'd1);
    checkOutput("job2_stall_busy", 64'(busy), 64'd1);
    applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("job2_rv", 64'(result_valid), 64'd1);
    checkOutput("job2_rm", 64'(result_match), 64'd0);
    checkOutput("job2_busy", 64'(busy), 64'd0);
    applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("job2_cleared_rv", 64'(result_valid), 64'd0);

    // Watchdog: two words queued with READY stuck low.
    applyStimulus(1'b1, 64'h0000_0000_0000_0B01, 16'h0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h0000_0000_0000_0B02, 16'h0002, 1'b0, 1'b0, 1'b0);
    checkOutput("wd_start_dv", 64'(DATA_VALID), 64'd1);
`ifdef PMM_FEEDER_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("wd_cycle%0d_tmo", k), 64'(timeout_err), 64'd0);
    end
    checkOutput("wd_pre_dv", 64'(DATA_VALID), 64'd1);
    applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("wd_tmo", 64'(timeout_err), 64'd1);
    checkOutput("wd_dv", 64'(DATA_VALID), 64'd0);
    checkOutput("wd_count", 64'(fifo_count), 64'd0);
    checkOutput("wd_busy", 64'(busy), 64'd0);
    applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("wd_tmo_cleared", 64'(timeout_err), 64'd0);
`else
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 64'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("nowd_dv_held", 64'(DATA_VALID), 64'd1);
    checkOutput("nowd_count", 64'(fifo_count), 64'd2);
    checkOutput("nowd_tmo", 64'(timeout_err), 64'd0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 64'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("nowd_drained_count", 64'(fifo_count), 64'd0);
    checkOutput("nowd_drained_dv", 64'(DATA_VALID), 64'd0);
`endif

    // Reset while sending with three entries queued.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, {32'hC000_0000, 32'(i)}, 16'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("rst_pre_dv", 64'(DATA_VALID), 64'd1);
    checkOutput("rst_pre_count", 64'(fifo_count), 64'd3);
    wr_en = 1'b0; rst = 1'b1;
    step();
    checkResetValues("midrst");
    rst = 1'b0;

    // Random traffic: the model is a plain queue of accepted words; every transfer must match its head.
    model_q.delete();
    for (int n = 0; n < 2000; n++) begin
      checkOutput($sformatf("rand%0d_count", n), 64'(fifo_count), 64'(model_q.size()));
      w   = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      c   = {($urandom_range(0, 3) == 0), 15'($urandom)};
      rdy = ($urandom_range(0, 3) != 0);
      acc = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 3) == 0);
      wr_en = w; wr_data = d; wr_ctrl = c;
      READY_STATUS = rdy; ACCEPTED_STATUS = acc; result_clear = clr;
      pre = model_q.size();
      if (DATA_VALID && rdy) begin
        if (model_q.size() == 0) begin
          checkOutput($sformatf("rand%0d_xfer_from_empty", n), 64'd1, 64'd0);
        end else begin
          head = model_q.pop_front();
          checkOutput($sformatf("rand%0d_xfer_data", n), INP_DATA, head[63:0]);
          checkOutput($sformatf("rand%0d_xfer_ctrl", n), 64'(INP_CONTROL), 64'(head[79:64]));
        end
      end
      if (w && pre < DEPTH) model_q.push_back({c, d});
      step();
    end
    checkOutput("rand_end_tmo", 64'(timeout_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
